// File: rtl/leb128_reader.sv
// leb128_reader
//
// Bus initiator that fetches one LEB128-encoded integer from the ROM read port
// byte by byte and returns the decoded 32-bit value in a single start/done
// transaction. Both unsigned (u32) and signed (i32) encodings of up to five
// bytes are supported.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start           begin a decode (sampled only while idle)
//   start_addr      address of the first encoded byte
//   is_signed       1 = i32 sign-extending decode, 0 = u32 (latched at start)
//   busy            high while a decode is in progress
//   done            one-cycle pulse; value / next_addr / error are valid
//   value           decoded result, held until the next completion
//   next_addr       address just past the last byte consumed
//   error           malformed encoding or timeout (valid with done)
//   rom_addr        ROM read address (stable while waiting for a byte)
//   rom_read_en     ROM read request
//   rom_data        ROM read data
//   rom_ready       ROM data-valid pulse
//
// Build option
//   LEB128_TIMEOUT_EN  when defined, adds parameter TIMEOUT_CYCLES (default 16)
//                      and a per-byte watchdog: if the ROM does not answer
//                      within TIMEOUT_CYCLES fetch cycles, the decode ends with
//                      error=1 and value = partial accumulator. When undefined
//                      the block waits for the ROM indefinitely.

module leb128_reader
`ifdef LEB128_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 16
)
`endif
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] start_addr,
    input  logic        is_signed,
    output logic        busy,
    output logic        done,
    output logic [31:0] value,
    output logic [31:0] next_addr,
    output logic        error,
    output logic [31:0] rom_addr,
    output logic        rom_read_en,
    input  logic [7:0]  rom_data,
    input  logic        rom_ready
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;

    logic [31:0] cur_addr_q, cur_addr_d;
    logic [31:0] acc_q, acc_d;
    logic [5:0]  shift_q, shift_d;
    logic [2:0]  count_q, count_d;
    logic        signed_q, signed_d;
    logic [31:0] value_q, value_d;
    logic [31:0] next_addr_q, next_addr_d;
    logic        error_q, error_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        rom_read_en_q, rom_read_en_d;

    // Per-byte results derived from the byte currently on rom_data.
    logic        capture_s;
    logic [31:0] byte_acc_s;
    logic [5:0]  byte_shift_s;
    logic [2:0]  byte_count_s;
    logic        fifth_s;
    logic        fifth_bad_s;
    logic        finish_s;
    logic        byte_err_s;
    logic [31:0] ext_value_s;
    logic        timeout_s;

    // Capture arithmetic: bits shifted past bit 31 simply fall off.
    always_comb begin
        capture_s    = (state_q == ST_FETCH) && rom_ready;
        byte_acc_s   = acc_q | ({25'd0, rom_data[6:0]} << shift_q);
        byte_shift_s = shift_q + 6'd7;
        byte_count_s = count_q + 3'd1;
        fifth_s      = (byte_count_s == 3'd5);
        finish_s     = capture_s && (!rom_data[7] || fifth_s);
    end

    // Fifth-byte range check: the 35-bit result must fit in 32 bits
    // (unsigned: top three payload bits clear; signed: top four bits equal).
    always_comb begin
        if (rom_data[7]) begin
            fifth_bad_s = 1'b1;
        end else if (signed_q) begin
            fifth_bad_s = !((rom_data[6:3] == 4'b0000) || (rom_data[6:3] == 4'b1111));
        end else begin
            fifth_bad_s = (rom_data[6:4] != 3'b000);
        end
        byte_err_s = fifth_s && fifth_bad_s;
    end

    // Sign extension from the terminating byte's bit 6 when bits remain above it.
    always_comb begin
        if (signed_q && !rom_data[7] && rom_data[6] && (byte_shift_s < 6'd32)) begin
            ext_value_s = byte_acc_s | (32'hFFFF_FFFF << byte_shift_s);
        end else begin
            ext_value_s = byte_acc_s;
        end
    end

`ifdef LEB128_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Watchdog counter: cleared on entry to FETCH and on every captured byte.
    always_comb begin
        if ((state_q == ST_IDLE) && start) begin
            tmo_d = '0;
        end else if (capture_s) begin
            tmo_d = '0;
        end else if (state_q == ST_FETCH) begin
            tmo_d = tmo_q + TMO_W'(1);
        end else begin
            tmo_d = tmo_q;
        end
        timeout_s = (state_q == ST_FETCH) && !rom_ready &&
                    (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    end

    // Watchdog counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (finish_s || timeout_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values. Results are loaded on the edge that
    // enters DONE so they are already valid while done is high.
    always_comb begin
        cur_addr_d    = cur_addr_q;
        acc_d         = acc_q;
        shift_d       = shift_q;
        count_d       = count_q;
        signed_d      = signed_q;
        value_d       = value_q;
        next_addr_d   = next_addr_q;
        error_d       = error_q;
        done_d        = 1'b0;
        busy_d        = (state_d != ST_IDLE);
        rom_read_en_d = (state_d == ST_FETCH);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cur_addr_d = start_addr;
                    signed_d   = is_signed;
                    acc_d      = 32'd0;
                    shift_d    = 6'd0;
                    count_d    = 3'd0;
                end else begin
                    cur_addr_d = cur_addr_q;
                end
            end
            ST_FETCH: begin
                if (capture_s) begin
                    cur_addr_d = cur_addr_q + 32'd1;
                    acc_d      = byte_acc_s;
                    shift_d    = byte_shift_s;
                    count_d    = byte_count_s;
                    if (finish_s) begin
                        value_d     = ext_value_s;
                        next_addr_d = cur_addr_q + 32'd1;
                        error_d     = byte_err_s;
                        done_d      = 1'b1;
                    end else begin
                        done_d = 1'b0;
                    end
                end else if (timeout_s) begin
                    value_d     = acc_q;
                    next_addr_d = cur_addr_q;
                    error_d     = 1'b1;
                    done_d      = 1'b1;
                end else begin
                    done_d = 1'b0;
                end
            end
            ST_DONE: begin
                done_d = 1'b0;
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr_q    <= 32'd0;
            acc_q         <= 32'd0;
            shift_q       <= 6'd0;
            count_q       <= 3'd0;
            signed_q      <= 1'b0;
            value_q       <= 32'd0;
            next_addr_q   <= 32'd0;
            error_q       <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            rom_read_en_q <= 1'b0;
        end else begin
            cur_addr_q    <= cur_addr_d;
            acc_q         <= acc_d;
            shift_q       <= shift_d;
            count_q       <= count_d;
            signed_q      <= signed_d;
            value_q       <= value_d;
            next_addr_q   <= next_addr_d;
            error_q       <= error_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
            rom_read_en_q <= rom_read_en_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign value       = value_q;
    assign next_addr   = next_addr_q;
    assign error       = error_q;
    assign rom_addr    = cur_addr_q;
    assign rom_read_en = rom_read_en_q;

endmodule

// File: tb/tb_leb128_reader.sv
// Self-checking bench for leb128_reader: directed cases plus randomized
// encodings, checked against an arithmetic LEB128 reference model. A small
// ROM responder with configurable wait states answers once per new address.

module tb_leb128_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] start_addr = 32'd0;
    logic        is_signed = 1'b0;
    logic        busy, done, error, rom_read_en;
    logic [31:0] value, next_addr, rom_addr;
    logic [7:0]  rom_data = 8'd0;
    logic        rom_ready = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    // ROM contents: enc[0..7] live at base..base+7, everything else reads 0.
    logic [7:0]  enc [0:7];
    logic [31:0] base = 32'd0;
    int          wait_states = 0;
    bit          mute = 1'b0;
    logic        served_v = 1'b0;
    logic [31:0] served_a = 32'd0;
    int          wcnt = 0;

    leb128_reader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_addr  (start_addr),
        .is_signed   (is_signed),
        .busy        (busy),
        .done        (done),
        .value       (value),
        .next_addr   (next_addr),
        .error       (error),
        .rom_addr    (rom_addr),
        .rom_read_en (rom_read_en),
        .rom_data    (rom_data),
        .rom_ready   (rom_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_byte(input logic [31:0] a);
        logic [31:0] off;
        off = a - base;
        if (off < 32'd8) return enc[off[2:0]];
        return 8'h00;
    endfunction

    // ROM responder: one data pulse per newly presented address, after wait states.
    always @(posedge clk) begin
        if (!rst_n || !rom_read_en) begin
            rom_ready <= 1'b0;
            served_v  <= 1'b0;
            wcnt      <= 0;
        end else if (mute || (served_v && rom_addr == served_a)) begin
            rom_ready <= 1'b0;
        end else if (wcnt < wait_states) begin
            wcnt      <= wcnt + 1;
            rom_ready <= 1'b0;
        end else begin
            rom_ready <= 1'b1;
            rom_data  <= rom_byte(rom_addr);
            served_v  <= 1'b1;
            served_a  <= rom_addr;
            wcnt      <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference decode of enc[] using 64-bit arithmetic on the whole number.
    task automatic model(input bit sgn, output logic [31:0] v, output logic [31:0] na,
                         output logic err, output int n);
        longint unsigned acc;
        longint          s;
        logic [7:0]      b;
        bit              term;
        acc = 0; term = 0; n = 0; err = 1'b0; b = 8'h00;
        for (int i = 0; i < 5; i++) begin
            b   = enc[i];
            acc = acc + (64'(b[6:0]) << (7 * i));
            n   = i + 1;
            if (!b[7]) begin
                term = 1;
                break;
            end
        end
        if (!term) begin
            err = 1'b1;
        end else if (n == 5) begin
            if (!sgn) begin
                err = (acc >= 64'h1_0000_0000);
            end else begin
                s   = acc[34] ? longint'(acc) - (64'sd1 <<< 35) : longint'(acc);
                err = (s < -64'sd2147483648) || (s > 64'sd2147483647);
            end
        end else if (sgn && b[6]) begin
            acc = acc - (64'd1 << (7 * n));
        end
        v  = acc[31:0];
        na = base + 32'(n);
    endtask

    // Canonical LEB128 encoding of v into enc[], returns byte count.
    task automatic encode(input logic [31:0] v, input bit sgn, output int n);
        logic [7:0]  b;
        int          sv;
        logic [31:0] uv;
        bit          more;
        uv = v; sv = v; n = 0; more = 1;
        while (more) begin
            if (sgn) begin
                b    = {1'b0, sv[6:0]};
                sv   = sv >>> 7;
                more = !((sv == 0 && !b[6]) || (sv == -1 && b[6]));
            end else begin
                b    = {1'b0, uv[6:0]};
                uv   = uv >> 7;
                more = (uv != 32'd0);
            end
            if (more) b[7] = 1'b1;
            enc[n] = b;
            n++;
        end
    endtask

    task automatic run_txn(input string tag, input logic [31:0] addr, input bit sgn,
                           input logic [31:0] ev, input logic [31:0] ena, input logic eerr,
                           input int elat, input bit poke);
        int edges;
        bit seen;
        start_addr = addr;
        is_signed  = sgn;
        start      = 1'b1;
        edges = 0;
        seen  = 0;
        while (!seen && edges < 400) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (edges == 1) begin
                start = 1'b0;
                check({tag, " busy"}, {31'd0, busy}, 32'd1);
            end
            if (poke && edges == 2) begin
                start      = 1'b1;
                start_addr = ~addr;
                is_signed  = ~sgn;
            end
            if (poke && edges == 3) start = 1'b0;
            if (done) seen = 1;
        end
        start = 1'b0;
        check({tag, " done_seen"}, {31'd0, seen}, 32'd1);
        if (elat >= 0) check({tag, " latency"}, edges, elat);
        check({tag, " value"}, value, ev);
        check({tag, " next_addr"}, next_addr, ena);
        check({tag, " error"}, {31'd0, error}, {31'd0, eerr});
        @(posedge clk);
        @(negedge clk);
        check({tag, " done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, " idle"}, {31'd0, busy}, 32'd0);
        check({tag, " value_held"}, value, ev);
    endtask

    task automatic set_enc(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3, input logic [7:0] b4);
        enc[0] = b0; enc[1] = b1; enc[2] = b2; enc[3] = b3; enc[4] = b4;
        enc[5] = 8'h00; enc[6] = 8'h00; enc[7] = 8'h00;
    endtask

    initial begin
        logic [31:0] rv, ev, ena;
        logic        eerr;
        int          n, w;
        bit          sgn;

        set_enc(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        repeat (3) @(negedge clk);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst error", {31'd0, error}, 32'd0);
        check("rst value", value, 32'd0);
        check("rst next_addr", next_addr, 32'd0);
        check("rst rom_addr", rom_addr, 32'd0);
        check("rst rom_read_en", {31'd0, rom_read_en}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        base = 32'h10; set_enc(8'hE5, 8'h8E, 8'h26, 8'h00, 8'h00);
        run_txn("u3", 32'h10, 1'b0, 32'h0009_8765, 32'h13, 1'b0, 7, 1'b0);
        base = 32'h200; set_enc(8'hC0, 8'hBB, 8'h78, 8'h00, 8'h00);
        run_txn("s3", 32'h200, 1'b1, 32'hFFFE_1DC0, 32'h203, 1'b0, 7, 1'b0);
        base = 32'h40; set_enc(8'h7F, 8'h00, 8'h00, 8'h00, 8'h00);
        run_txn("u1", 32'h40, 1'b0, 32'h0000_007F, 32'h41, 1'b0, 3, 1'b0);
        run_txn("s1", 32'h40, 1'b1, 32'hFFFF_FFFF, 32'h41, 1'b0, 3, 1'b0);
        base = 32'h80; set_enc(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F);
        run_txn("u5max", 32'h80, 1'b0, 32'hFFFF_FFFF, 32'h85, 1'b0, 11, 1'b0);
        set_enc(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h1F);
        run_txn("u5bad", 32'h80, 1'b0, 32'hFFFF_FFFF, 32'h85, 1'b1, 11, 1'b0);
        set_enc(8'h80, 8'h80, 8'h80, 8'h80, 8'h80);
        run_txn("cont5", 32'h80, 1'b0, 32'h0000_0000, 32'h85, 1'b1, 11, 1'b0);
        set_enc(8'h80, 8'h80, 8'h80, 8'h80, 8'h78);
        run_txn("s5neg", 32'h80, 1'b1, 32'h8000_0000, 32'h85, 1'b0, 11, 1'b0);
        base = 32'hFFFF_FFFE; set_enc(8'hE5, 8'h8E, 8'h26, 8'h00, 8'h00);
        run_txn("wrap", 32'hFFFF_FFFE, 1'b0, 32'h0009_8765, 32'h1, 1'b0, 7, 1'b0);

        // Reset in the middle of a fetch.
        base = 32'h300; set_enc(8'h80, 8'h80, 8'h05, 8'h00, 8'h00);
        wait_states = 3;
        start_addr = 32'h300; is_signed = 1'b0; start = 1'b1;
        @(posedge clk); @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst rom_read_en", {31'd0, rom_read_en}, 32'd0);
        check("midrst busy", {31'd0, busy}, 32'd0);
        check("midrst done", {31'd0, done}, 32'd0);
        check("midrst value", value, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_states = 0;
        set_enc(8'h05, 8'h00, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        run_txn("after_rst", 32'h300, 1'b0, 32'd5, 32'h301, 1'b0, 3, 1'b0);

        // Silent responder.
        mute = 1'b1;
        base = 32'h500; set_enc(8'h85, 8'h00, 8'h00, 8'h00, 8'h00);
`ifdef LEB128_TIMEOUT_EN
        run_txn("timeout", 32'h500, 1'b0, 32'd0, 32'h500, 1'b1, 17, 1'b0);
        mute = 1'b0;
`else
        start_addr = 32'h500; is_signed = 1'b0; start = 1'b1;
        @(posedge clk); @(negedge clk); start = 1'b0;
        repeat (60) @(negedge clk);
        check("hang busy", {31'd0, busy}, 32'd1);
        check("hang done", {31'd0, done}, 32'd0);
        mute = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`endif

        // Randomized transactions.
        for (int t = 0; t < 40; t++) begin
            base = $urandom;
            sgn  = $urandom_range(0, 1);
            w    = $urandom_range(0, 2);
            wait_states = w;
            for (int k = 0; k < 8; k++) enc[k] = 8'h00;
            if ($urandom_range(0, 2) != 0) begin
                rv = $urandom;
                if ($urandom_range(0, 1) == 1) rv = rv >> $urandom_range(0, 31);
                if (sgn && $urandom_range(0, 1) == 1) rv = -rv;
                encode(rv, sgn, n);
                ev = rv; ena = base + 32'(n); eerr = 1'b0;
            end else begin
                for (int k = 0; k < 5; k++) begin
                    enc[k] = 8'($urandom);
                    if (k < 4 && $urandom_range(0, 3) != 0) enc[k][7] = 1'b1;
                end
                model(sgn, ev, ena, eerr, n);
            end
            run_txn($sformatf("rnd%0d", t), base, sgn, ev, ena, eerr, n * (2 + w) + 1,
                    $urandom_range(0, 1) == 1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
